// File: rtl/jk_cmd_driver.sv
// Command sequencer for a single-bit JK flip-flop stage: applies op/repeat
// commands one J/K pulse at a time and checks the fed-back Q against a model.
module jk_cmd_driver #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_rep,
    output logic             J,
    output logic             K,
    input  logic             q_fb,
    output logic             exp_q,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_op;
    logic [1:0]         w_op_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_j;
    logic               r_k;
    logic               w_j_nxt;
    logic               w_k_nxt;
    logic               r_exp_q;
    logic               w_exp_q_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_accept;

    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // NOTE: every register carries the async reset, so a mid-command reset
    // drops J/K immediately instead of waiting for the next clock edge.
    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together and no read-before-write ordering leaks in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here receives a default first, so no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_j_nxt     = 1'b0;
        w_k_nxt     = 1'b0;
        w_exp_q_nxt = r_exp_q;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // J/K are registered, so the first pulse is loaded on the
                    // accept edge to appear during the DRIVE cycle.
                    w_op_nxt    = cmd_op;
                    w_cnt_nxt   = cmd_rep;
                    w_exp_q_nxt = q_fb;
                    w_err_nxt   = 1'b0;
                    w_j_nxt     = cmd_op[1];
                    w_k_nxt     = cmd_op[0];
                    w_state_nxt = S_DRIVE;
                end
            end

            S_DRIVE: begin
                case (r_op)
                    2'b01:   w_exp_q_nxt = 1'b0;
                    2'b10:   w_exp_q_nxt = 1'b1;
                    2'b11:   w_exp_q_nxt = ~r_exp_q;
                    default: w_exp_q_nxt = r_exp_q;
                endcase
                w_state_nxt = S_CHECK;
            end

            S_CHECK: begin
                if (q_fb != r_exp_q) begin
                    w_err_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_j_nxt     = r_op[1];
                    w_k_nxt     = r_op[0];
                    w_state_nxt = S_DRIVE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 2'b00;
            r_cnt   <= '0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_exp_q <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_exp_q <= w_exp_q_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign J     = r_j;
    assign K     = r_k;
    assign exp_q = r_exp_q;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver with a behavioural JK stage closing the loop.
module tb_jk_cmd_driver;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_rep;
    logic             J;
    logic             K;
    logic             q_fb;
    logic             exp_q;
    logic             done;
    logic             err;

    logic q_stage;
    logic fault_en;

    int n_checks;
    int n_errors;

    int n_cyc;
    int j_pulses;
    int k_pulses;
    int ready_busy;
    int nq;
    logic qseq [0:15];
    int jk_viol;
    logic prev_jk_mon;
    logic prev_jk;
    logic saw_done;

    jk_cmd_driver #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rep   (cmd_rep),
        .J         (J),
        .K         (K),
        .q_fb      (q_fb),
        .exp_q     (exp_q),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream JK stage; it has no reset and holds whatever Q it had.
    initial q_stage = 1'b0;
    always @(posedge clk) begin
        case ({J, K})
            2'b01:   q_stage <= 1'b0;
            2'b10:   q_stage <= 1'b1;
            2'b11:   q_stage <= ~q_stage;
            default: q_stage <= q_stage;
        endcase
    end

    assign q_fb = fault_en ? 1'b0 : q_stage;

    // J/K must never be high on two consecutive cycles.
    initial begin
        jk_viol     = 0;
        prev_jk_mon = 1'b0;
    end
    always @(negedge clk) begin
        if ((J | K) && prev_jk_mon) jk_viol++;
        prev_jk_mon = J | K;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Presents a command at a negedge; returns at the next negedge (DRIVE cycle).
    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] rep);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rep   = rep;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_rep   = '0;
    endtask

    // Called at a negedge inside a command; counts cycles up to the done cycle.
    task automatic wait_done();
        n_cyc      = 0;
        nq         = 0;
        j_pulses   = int'(J);
        k_pulses   = int'(K);
        ready_busy = int'(cmd_ready);
        prev_jk    = J | K;
        while (!done && n_cyc < 100) begin
            @(negedge clk);
            n_cyc++;
            if (prev_jk && nq < 16) begin
                qseq[nq] = q_fb;
                nq++;
            end
            if (!done) begin
                j_pulses   += int'(J);
                k_pulses   += int'(K);
                ready_busy += int'(cmd_ready);
            end
            prev_jk = J | K;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        fault_en  = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_rep   = '0;
        rst_n     = 1'b0;

        #3;
        check("rst_J", J, 1'b0);
        check("rst_K", K, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_exp_q", exp_q, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Set once: single J pulse, done 2 cycles after accept.
        issue(2'b10, 4'd0);
        check("set_J", J, 1'b1);
        check("set_K", K, 1'b0);
        check("set_ready_busy", cmd_ready, 1'b0);
        wait_done();
        check("set_cycles", n_cyc, 2);
        check("set_jpulses", j_pulses, 1);
        check("set_q", q_fb, 1'b1);
        check("set_exp_q", exp_q, 1'b1);
        check("set_err", err, 1'b0);
        check("set_ready_done", cmd_ready, 1'b1);
        @(negedge clk);
        check("set_done_1cyc", done, 1'b0);

        // Toggle x4 from Q=1.
        issue(2'b11, 4'd3);
        check("tog_JK", {J, K}, 2'b11);
        wait_done();
        check("tog_cycles", n_cyc, 8);
        check("tog_pulses", j_pulses + k_pulses, 8);
        check("tog_qseq", {qseq[0], qseq[1], qseq[2], qseq[3]}, 4'b0101);
        check("tog_exp_q", exp_q, 1'b1);
        check("tog_err", err, 1'b0);

        // Clear with maximum repeat: 16 applications.
        issue(2'b01, 4'd15);
        wait_done();
        check("clr_cycles", n_cyc, 32);
        check("clr_kpulses", k_pulses, 16);
        check("clr_jpulses", j_pulses, 0);
        check("clr_ready_busy", ready_busy, 0);
        check("clr_ready_done", cmd_ready, 1'b1);
        check("clr_q", q_fb, 1'b0);
        check("clr_exp_q", exp_q, 1'b0);
        check("clr_err", err, 1'b0);

        // Fault: Q forced low while setting.
        fault_en = 1'b1;
        issue(2'b10, 4'd2);
        @(negedge clk);
        check("flt_err_pre", err, 1'b0);
        @(negedge clk);
        check("flt_err_first", err, 1'b1);
        wait_done();
        check("flt_done", done, 1'b1);
        check("flt_err_sticky", err, 1'b1);
        fault_en = 1'b0;
        @(negedge clk);
        check("flt_err_hold", err, 1'b1);
        issue(2'b00, 4'd0);
        check("hold_err_clr", err, 1'b0);
        check("hold_JK", {J, K}, 2'b00);
        wait_done();
        check("hold_cycles", n_cyc, 2);
        check("hold_q", q_fb, 1'b1);
        check("hold_exp_q", exp_q, 1'b1);
        check("hold_err", err, 1'b0);

        // Back-to-back: valid held across the done cycle.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_rep   = 4'd0;
        @(negedge clk);
        cmd_op    = 2'b01;
        @(negedge clk);
        check("b2b_mid_done", done, 1'b0);
        @(negedge clk);
        check("b2b_done1", done, 1'b1);
        check("b2b_ready1", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_second_drive", {J, K}, 2'b01);
        check("b2b_done_drop", done, 1'b0);
        wait_done();
        check("b2b_cycles", n_cyc, 2);
        check("b2b_q", q_fb, 1'b0);
        check("b2b_exp_q", exp_q, 1'b0);
        @(negedge clk);

        // Async reset during DRIVE of a toggle command.
        issue(2'b11, 4'd5);
        check("rstm_JK_before", {J, K}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check("rstm_JK_async", {J, K}, 2'b00);
        check("rstm_ready", cmd_ready, 1'b1);
        check("rstm_exp_q", exp_q, 1'b0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("rstm_no_done", saw_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstm_idle_ready", cmd_ready, 1'b1);
        check("rstm_q", q_fb, 1'b0);
        issue(2'b10, 4'd1);
        wait_done();
        check("rstm_cycles", n_cyc, 4);
        check("rstm_q_after", q_fb, 1'b1);
        check("rstm_exp_after", exp_q, 1'b1);
        check("rstm_err_after", err, 1'b0);

        check("jk_consecutive", jk_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/jk_cmd_driver.md
Name: jk_cmd_driver

Overview:
- Upstream command sequencer for the single-bit JK flip-flop stage.
- Accepts op/repeat commands over a valid/ready handshake and drives the flip-flop's J/K inputs one application at a time.
- After each application it reads back Q (q_fb) and checks it against an internally tracked expected value.
- Reports completion (done) and mismatch (err) to the controller.

Parameters:
- CNT_W, 4, width of the repeat field; a command performs cmd_rep+1 applications (1..2^CNT_W).

Ports:
- clk  input  1  system clock, rising edge; shared with the downstream JK stage.
- rst_n  input  1  asynchronous reset, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command; high only in IDLE.
- cmd_op  input  2  00 hold, 01 clear, 10 set, 11 toggle; same encoding as {J,K}.
- cmd_rep  input  CNT_W  repeat count minus one.
- J  output  1  to JK stage J input.
- K  output  1  to JK stage K input.
- q_fb  input  1  Q fed back from the JK stage.
- exp_q  output  1  tracked expected Q.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  sticky mismatch flag, cleared on the next command accept.

Behaviour:
- Reset (rst_n low, asynchronous), held until rst_n deasserts:
  - state=IDLE, J=0, K=0, cmd_ready=1, done=0, err=0, exp_q=0, repeat counter=0.
  - Reset mid-command aborts immediately; J/K drop to 0 without waiting for a clock edge.
  - No done pulse is produced for the aborted command.
- All outputs are registered except cmd_ready, which is decoded from state=IDLE.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE:
  - J=K=0.
  - On a posedge with cmd_valid&&cmd_ready: latch op, load counter=cmd_rep, capture exp_q<=q_fb, clear err, go to DRIVE.
  - Q is stable at this point because J=K=0.
- DRIVE (one cycle):
  - {J,K}=latched op.
  - The JK stage samples J/K at the posedge that ends this cycle.
  - At the same edge exp_q updates: 00 keep, 01 to 0, 10 to 1, 11 invert. Go to CHECK.
- CHECK (one cycle):
  - J=K=0. q_fb now reflects the application.
  - At the posedge ending CHECK: if q_fb!=exp_q, err<=1 (sticky).
  - If counter==0: go to IDLE with done<=1 for exactly one cycle.
  - Otherwise: counter<=counter-1, go to DRIVE.
- Timing:
  - J/K are never asserted two consecutive cycles.
  - Each application takes 2 cycles; a command takes 2*(cmd_rep+1) cycles from accept to the done edge.
- done and cmd_ready are both high in the first IDLE cycle, so a new command may be accepted on that edge (back-to-back). The accept edge clears err and done deasserts.
- cmd_op and cmd_rep are sampled only at accept; later changes are ignored.
- cmd_valid is ignored outside IDLE.
- Counter wrap: cmd_rep=all-ones gives 2^CNT_W applications; the counter must not underflow.
- Hold op (00) still runs its DRIVE/CHECK cycles with J=K=0 and checks that Q is unchanged.
- err stays high after done until the next accept; it is not cleared by done.

Test Plan:
- Reset with Q=0, then cmd op=10 rep=0: J=1,K=0 for exactly one cycle. Q becomes 1, exp_q=1, done pulses 2 cycles after accept, err=0.
- op=11 rep=3, starting Q=1: J=K=1 pulses on alternate cycles. Q sequence 0,1,0,1, exp_q ends 1, done at 8 cycles after accept, err=0.
- op=01 rep=15 (counter wrap): 16 clear pulses, done after 32 cycles, Q=0, err=0. cmd_ready low throughout, high in the done cycle.
- Fault injection: force q_fb=0 while op=10 is executing. err=1 at the end of the first CHECK and remains 1 after done. The next accept clears err.
- Back-to-back: cmd_valid held high with op=10 then op=01. The second command is accepted in the done cycle of the first, with no idle gap; final Q=0.
- Assert rst_n low during DRIVE of op=11 rep=5: J=K=0 asynchronously, no done pulse, state IDLE, cmd_ready=1. After release, a new command runs correctly.
